// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory responder with LATENCY wait states and RISC-V load/store lane handling.
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned or reserved-func3 accesses raise rsp_err instead of aligning.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  state_e        state, stateNext;
  logic [3:0]    waitCnt, waitCntNext;
  logic          commitEn;

  logic          reqWe;
  logic [2:0]    reqFunc3;
  logic [AW+1:0] reqAddr;
  logic [31:0]   reqWdata;

  logic          curWe;
  logic [2:0]    curFunc3;
  logic [AW+1:0] curAddr;
  logic [31:0]   curWdata;
  logic [AW-1:0] wordIdx;

  size_e         accSize;
  logic [1:0]    byteOff;
  logic          accErr;
  logic [3:0]    byteEn;
  logic [31:0]   wdataLanes;
  logic [31:0]   memWord;
  logic [7:0]    byteSel;
  logic [15:0]   halfSel;
  logic [31:0]   loadData;

  logic [31:0]   rspRdata;
  logic          rspErr;

  logic [31:0]   mem [DEPTH];

  // Address bits above the array size wrap away.
  logic unusedAddrBits;
  assign unusedAddrBits = ^req_addr[31:AW+2];

  // With LATENCY=1 the commit shares the accept edge, so the live request is used in IDLE.
  always_comb begin
    if (state == IDLE) begin
      curWe    = req_we;
      curFunc3 = req_func3;
      curAddr  = req_addr[AW+1:0];
      curWdata = req_wdata;
    end else begin
      curWe    = reqWe;
      curFunc3 = reqFunc3;
      curAddr  = reqAddr;
      curWdata = reqWdata;
    end
  end

  assign wordIdx = curAddr[AW+1:2];

  always_comb begin
    case (curFunc3[1:0])
      2'b00:   accSize = SZ_BYTE;
      2'b01:   accSize = SZ_HALF;
      default: accSize = SZ_WORD;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    byteOff = curAddr[1:0];
    accErr  = (curFunc3 == 3'b011) || (curFunc3[2:1] == 2'b11);
    if (accSize == SZ_HALF && curAddr[0])
      accErr = 1'b1;
    if (accSize == SZ_WORD && curAddr[1:0] != 2'b00)
      accErr = 1'b1;
  end
`else
  always_comb begin
    byteOff = curAddr[1:0];
    case (accSize)
      SZ_HALF: byteOff[0] = 1'b0;
      SZ_WORD: byteOff    = 2'b00;
      default: ;
    endcase
    accErr = 1'b0;
  end
`endif

  always_comb begin
    byteEn     = 4'b1111;
    wdataLanes = curWdata;
    case (accSize)
      SZ_BYTE: begin
        byteEn     = 4'b0001 << byteOff;
        wdataLanes = {4{curWdata[7:0]}};
      end
      SZ_HALF: begin
        byteEn     = byteOff[1] ? 4'b1100 : 4'b0011;
        wdataLanes = {2{curWdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    memWord = mem[wordIdx];
    byteSel = memWord[{byteOff, 3'b000} +: 8];
    halfSel = byteOff[1] ? memWord[31:16] : memWord[15:0];
    case (accSize)
      SZ_BYTE: loadData = {{24{byteSel[7] & ~curFunc3[2]}}, byteSel};
      SZ_HALF: loadData = {{16{halfSel[15] & ~curFunc3[2]}}, halfSel};
      default: loadData = memWord;
    endcase
    if (accErr)
      loadData = '0;
  end

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    commitEn    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            stateNext = RESP;
            commitEn  = 1'b1;
          end else begin
            stateNext   = WAIT;
            waitCntNext = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (waitCnt == 4'd0) begin
          stateNext = RESP;
          commitEn  = 1'b1;
        end else begin
          waitCntNext = waitCnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready)
          stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      waitCnt <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reqWe    <= 1'b0;
      reqFunc3 <= '0;
      reqAddr  <= '0;
      reqWdata <= '0;
      rspRdata <= '0;
      rspErr   <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        reqWe    <= req_we;
        reqFunc3 <= req_func3;
        reqAddr  <= req_addr[AW+1:0];
        reqWdata <= req_wdata;
      end
      if (commitEn) begin
        rspRdata <= curWe ? 32'd0 : loadData;
        rspErr   <= accErr;
      end
    end
  end

  // NOTE: the array is deliberately not reset; contents survive rst_n and change only on a store commit.
  always_ff @(posedge clk) begin
    if (rst_n && commitEn && curWe && !accErr) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b])
          mem[wordIdx][b*8 +: 8] <= wdataLanes[b*8 +: 8];
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign rsp_rdata = rspRdata;
  assign rsp_err   = rspErr;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench with a byte-array reference model checked every cycle plus literal expectations.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;
  localparam logic [2:0] F_RS = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_func3 (req_func3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte-addressed store plus "response is due LAT edges after accept".
  logic [7:0]  mdl [int unsigned];
  int unsigned edgeNo = 0;
  int unsigned tAcceptEdge;
  bit          mBusy = 0, mRsp = 0, mErr = 0;
  logic [31:0] mRdata = '0;
  bit          tWe;
  logic [2:0]  tF3;
  logic [31:0] tAddr, tWdata;

  task automatic modelCommit();
    int unsigned n, a;
    bit bad;
    logic [31:0] v;
    n   = (tF3[1:0] == 2'b00) ? 1 : (tF3[1:0] == 2'b01) ? 2 : 4;
    a   = tAddr % (4 * DEPTH);
    bad = (tF3 == 3'b011) || (tF3 == 3'b110) || (tF3 == 3'b111) || (a % n != 0);
`ifndef DMEM_MISALIGN_TRAP_EN
    bad = 0;
    a   = a - (a % n);
`endif
    mErr   = bad;
    mRdata = '0;
    if (!bad) begin
      if (tWe) begin
        for (int i = 0; i < int'(n); i++) mdl[a + i] = tWdata[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < int'(n); i++) v = v | (32'(mdl[a + i]) << (8 * i));
        if (n < 4 && !tF3[2] && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        mRdata = v;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mBusy  = 0;
      mRsp   = 0;
      mErr   = 0;
      mRdata = '0;
    end else begin
      edgeNo++;
      if (!mBusy) begin
        if (req_valid) begin
          tWe = req_we; tF3 = req_func3; tAddr = req_addr; tWdata = req_wdata;
          tAcceptEdge = edgeNo;
          mBusy = 1;
        end
      end else if (mRsp) begin
        if (rsp_ready) begin
          mBusy = 0;
          mRsp  = 0;
        end
      end
      if (mBusy && !mRsp && edgeNo == tAcceptEdge + LAT - 1) begin
        modelCommit();
        mRsp = 1;
      end
    end
  end

  always @(negedge clk) begin
    check("req_ready", 32'(req_ready), 32'(!mBusy));
    check("busy", 32'(busy), 32'(mBusy));
    check("rsp_valid", 32'(rsp_valid), 32'(mRsp));
    if (mRsp) begin
      check("rsp_rdata", rsp_rdata, mRdata);
      check("rsp_err", 32'(rsp_err), 32'(mErr));
    end
  end

  task automatic drive(input bit we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1;
    req_we    = we;
    req_func3 = f3;
    req_addr  = addr;
    req_wdata = wd;
  endtask

  task automatic waitAccept(input bit keepValid);
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    if (!keepValid) req_valid = 1'b0;
  endtask

  task automatic waitRsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (rsp_valid !== 1'b1 && lat < 50);
    check("rsp_wait", 32'(rsp_valid), 32'd1);
  endtask

  task automatic txn(input bit we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rdata, output logic err, output int lat);
    @(negedge clk);
    drive(we, f3, addr, wd);
    waitAccept(1'b0);
    waitRsp(lat);
    rdata = rsp_rdata;
    err   = rsp_err;
  endtask

  logic [31:0] rd, hold;
  logic        er;
  int          lat;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_func3 = '0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    #2 rst_n = 1'b1;

    // 1: store/load round trip, latency 2
    txn(1, F_W, 32'h10, 32'hDEADBEEF, rd, er, lat);
    check("t1_sw_lat", 32'(lat), 32'd2);
    check("t1_sw_rdata", rd, 32'd0);
    txn(0, F_W, 32'h10, 32'h0, rd, er, lat);
    check("t1_lw_lat", 32'(lat), 32'd2);
    check("t1_lw_rdata", rd, 32'hDEADBEEF);
    check("t1_lw_err", 32'(er), 32'd0);

    // 2: byte store and sign/zero-extended byte loads
    txn(1, F_W, 32'h10, 32'h11223344, rd, er, lat);
    txn(1, F_B, 32'h13, 32'h00000080, rd, er, lat);
    txn(0, F_B, 32'h13, 32'h0, rd, er, lat);
    check("t2_lb", rd, 32'hFFFFFF80);
    txn(0, F_BU, 32'h13, 32'h0, rd, er, lat);
    check("t2_lbu", rd, 32'h00000080);
    txn(0, F_W, 32'h10, 32'h0, rd, er, lat);
    check("t2_lw", rd, 32'h80223344);

    // 3: halfword store into upper half
    txn(1, F_W, 32'h20, 32'hCAFE1234, rd, er, lat);
    txn(1, F_H, 32'h22, 32'h00008001, rd, er, lat);
    txn(0, F_H, 32'h22, 32'h0, rd, er, lat);
    check("t3_lh", rd, 32'hFFFF8001);
    txn(0, F_HU, 32'h22, 32'h0, rd, er, lat);
    check("t3_lhu", rd, 32'h00008001);
    txn(0, F_H, 32'h20, 32'h0, rd, er, lat);
    check("t3_lh_low", rd, 32'h00001234);

    // address wraps modulo 4*DEPTH bytes
    txn(1, F_W, 32'h00001010, 32'hA5A50F0F, rd, er, lat);
    txn(0, F_W, 32'h10, 32'h0, rd, er, lat);
    check("wrap_lw", rd, 32'hA5A50F0F);

    // 4: response back-pressure with a second request pending
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(0, F_W, 32'h20, 32'h0);
    waitAccept(1'b1);
    req_func3 = F_BU;
    req_addr  = 32'h22;
    waitRsp(lat);
    hold = rsp_rdata;
    check("t4_first_rdata", hold, 32'h80011234);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_valid", 32'(rsp_valid), 32'd1);
      check("t4_hold_rdata", rsp_rdata, hold);
      check("t4_hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t4_ready_after", 32'(req_ready), 32'd1);
    check("t4_valid_drop", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("t4_second_busy", 32'(busy), 32'd1);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("t4_second_rdata", rsp_rdata, 32'h00000001);

    // 5: reset during WAIT drops the pending store
    txn(1, F_W, 32'h40, 32'h12345678, rd, er, lat);
    txn(0, F_W, 32'h40, 32'h0, rd, er, lat);
    check("t5_pre_lw", rd, 32'h12345678);
    @(negedge clk);
    drive(1, F_W, 32'h40, 32'h00000005);
    waitAccept(1'b0);
    @(negedge clk);
    check("t5_in_wait", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_ready", 32'(req_ready), 32'd1);
    check("t5_rst_valid", 32'(rsp_valid), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_rdata", rsp_rdata, 32'd0);
    check("t5_rst_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    txn(0, F_W, 32'h40, 32'h0, rd, er, lat);
    check("t5_old_contents", rd, 32'h12345678);

    // 6: misaligned word load and reserved func3
    txn(0, F_W, 32'h41, 32'h0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("t6_mis_rdata", rd, 32'd0);
    check("t6_mis_err", 32'(er), 32'd1);
`else
    check("t6_mis_rdata", rd, 32'h12345678);
    check("t6_mis_err", 32'(er), 32'd0);
`endif
    txn(0, F_RS, 32'h40, 32'h0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("t6_rsv_rdata", rd, 32'd0);
    check("t6_rsv_err", 32'(er), 32'd1);
`else
    check("t6_rsv_rdata", rd, 32'h12345678);
    check("t6_rsv_err", 32'(er), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for data accesses issued by the pipeline MEM stage. It accepts one load or store request at a time through a valid/ready handshake.
- It services each request against an internal word array after a programmable number of wait states.
- It returns a response through a second valid/ready handshake. Load data is byte/halfword/word-selected and sign- or zero-extended according to RISC-V func3.
- This block replaces the single-cycle data memory when a stall-capable memory path is needed.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array (power of two).
- LATENCY, 2, cycles from the request-accept edge to rsp_valid high; legal range 1..15.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_func3  in  3  RISC-V funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu)
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low byte/half used for sb/sh)
- rsp_valid  out  1  response present
- rsp_ready  in  1  pipeline accepts response
- rsp_rdata  out  32  extended load data; 0 for stores
- rsp_err  out  1  access error (see Optional Feature)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; busy=0; wait counter=0.
  - Array contents are not cleared.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, register we/func3/addr/wdata.
  - If LATENCY=1, go to RESP. Otherwise go to WAIT with counter=LATENCY-2.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle. When it is 0, go to RESP.
- Commit on the transition edge into RESP:
  - Store: write enabled byte lanes.
    - sb: lane addr[1:0].
    - sh: lanes {addr[1],0} and {addr[1],1}.
    - sw: all lanes.
  - Load: capture word and extract the field.
    - lb/lh: sign-extend.
    - lbu/lhu: zero-extend.
    - lw: whole word.
  - Reserved func3 (011, 110, 111) is treated as a word access.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready=1.
  - On rsp_valid&rsp_ready, go to IDLE and rsp_valid drops next cycle.
  - Minimum request-to-request spacing is LATENCY+1 cycles.
- Word index is addr[log2(DEPTH)+1:2]; upper address bits are ignored (the address wraps modulo 4*DEPTH bytes).
- No new request is accepted while in WAIT or RESP; req_valid there is ignored and must be held by the initiator.
- A later load observes a prior store to the same address (commit precedes any following accept).
- Reset asserted in WAIT drops the pending store (not yet committed). Reset asserted in RESP drops the response; a store there is already committed.
- rsp_ready held high in IDLE/WAIT has no effect.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned accesses are lh/lhu/sh with addr[0]=1, and lw/sw with addr[1:0]≠00. Reserved func3 values are also illegal.
  - Any of these sets rsp_err=1 in RESP.
  - A store does not write; a load returns rsp_rdata=0.
  - Handshake and latency are unchanged.
- Undefined:
  - rsp_err is tied 0.
  - Low address bits are forced to alignment: addr[0] is cleared for halfwords and addr[1:0] for words.
  - Reserved func3 is treated as lw.

Test Plan:
1. Reset, then sw addr 0x10 data 0xDEADBEEF, then lw 0x10 with rsp_ready=1 -> rsp_valid exactly 2 cycles after each accept, rdata 0xDEADBEEF, rsp_err 0.
2. sb 0x80 at addr 0x13 over word 0x11223344, then lb 0x13 / lbu 0x13 -> rdata 0xFFFFFF80 / 0x00000080; lw 0x10 -> 0x80223344.
3. sh 0x8001 at 0x22, then lh 0x22 / lhu 0x22 -> 0xFFFF8001 / 0x00008001; lh 0x20 unchanged.
4. Hold rsp_ready=0 for 5 cycles with a second req_valid pending -> rsp_valid and rdata stable, req_ready=0; second request is accepted the cycle after rsp_ready=1.
5. Pulse rst_n low during WAIT of sw 0x40 data 0x5 -> outputs return to reset values immediately; lw 0x40 afterwards returns the old contents.
6. With DMEM_MISALIGN_TRAP_EN defined: lw 0x41 -> rsp_err=1, rdata=0. Without the macro: lw 0x41 reads word 0x40, rsp_err=0.
